// File: rtl/ball_joint_pkg.sv
// Shared constants and types for the ball-joint sample filter: register map,
// accumulator format and the filter sequencing states.
package ball_joint_pkg;

  localparam int ACC_W     = 16;
  localparam int FRAC_BITS = 4;
  localparam int RAW_W     = 12;

  localparam logic [7:0] REG_X       = 8'h00;
  localparam logic [7:0] REG_Y       = 8'h01;
  localparam logic [7:0] REG_Z       = 8'h02;
  localparam logic [7:0] REG_TEMP    = 8'h03;
  localparam logic [7:0] REG_COUNT   = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h05;
  localparam logic [7:0] REG_ERR     = 8'h06;
  localparam logic [7:0] REG_SHIFT   = 8'h10;
  localparam logic [7:0] REG_CLEAR   = 8'h11;
  localparam logic [7:0] REG_TIMEOUT = 8'h12;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILT_X = 3'd1,
    ST_FILT_Y = 3'd2,
    ST_FILT_Z = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/ball_joint_ema.sv
// Single-axis exponential moving average step in Q12.4; the first sample of a
// sensor loads the accumulator directly.
module ball_joint_ema
  import ball_joint_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [RAW_W-1:0] sample,
  input  logic        [2:0]       shift,
  input  logic                    primed,
  output logic signed [ACC_W-1:0] acc_next
);

  function automatic logic signed [ACC_W-1:0] wrap_acc(input logic signed [ACC_W:0] v);
    return v[ACC_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] target;
  logic signed [ACC_W:0]   diff;
  logic signed [ACC_W:0]   step;
  logic signed [ACC_W:0]   sum;

  // Difference needs the extra bit: target and acc can sit at opposite full scale.
  assign target   = {sample, {FRAC_BITS{1'b0}}};
  assign diff     = {target[ACC_W-1], target} - {acc[ACC_W-1], acc};
  assign step     = diff >>> shift;
  assign sum      = {acc[ACC_W-1], acc} + step;
  assign acc_next = primed ? wrap_acc(sum) : target;

endmodule

// File: rtl/ball_joint_sample_filter.sv
// Per-sensor EMA filter over raw ball-joint samples with sample counts,
// staleness tracking and an Avalon-MM register window.
module ball_joint_sample_filter
  import ball_joint_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 4,
  parameter int DEFAULT_SHIFT     = 3,
  parameter int DEFAULT_TIMEOUT   = 2_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [7:0]  sample_sensor,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  input  logic [11:0] sample_temp,
  input  logic [15:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest
);

  localparam int         SIDX_W = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;
  localparam logic [7:0] N_SENS = 8'(NUMBER_OF_SENSORS);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] filt_out(input logic signed [ACC_W-1:0] a);
    logic signed [31:0] wide;
    wide = {{(32-ACC_W){a[ACC_W-1]}}, a};
    return wide >>> FRAC_BITS;
  endfunction

  state_t state;
  logic   wait_flag;
  logic [2:0]  shift_q;
  logic [31:0] timeout_q;
  logic [15:0] err_count;

  logic signed [ACC_W-1:0] acc [NUMBER_OF_SENSORS][3];
  logic [11:0] temp      [NUMBER_OF_SENSORS];
  logic [31:0] count     [NUMBER_OF_SENSORS];
  logic [31:0] timer     [NUMBER_OF_SENSORS];
  logic [NUMBER_OF_SENSORS-1:0] primed;
  logic [NUMBER_OF_SENSORS-1:0] stale;

  logic [SIDX_W-1:0]       sensor_p0;
  logic signed [RAW_W-1:0] x_p0, y_p0, z_p0;
  logic [11:0]             temp_p0;
  logic [2:0]              shift_p0;

  logic capture, sensor_ok, start, filt_active, wr_ok, wr_clear;
  logic [1:0]              axis;
  logic signed [RAW_W-1:0] axis_sample;
  logic signed [ACC_W-1:0] acc_next;
  logic [SIDX_W-1:0]       rd_sensor;
  logic                    rd_sens_ok;
  logic [31:0]             rd_value;

  assign sample_ready = (state == ST_IDLE) && !write;
  assign waitrequest  = (state != ST_IDLE) || (read && wait_flag);
  assign capture      = sample_valid && sample_ready;
  assign sensor_ok    = sample_sensor < N_SENS;
  assign start        = capture && sensor_ok;
  assign filt_active  = (state == ST_FILT_X) || (state == ST_FILT_Y) || (state == ST_FILT_Z);
  assign wr_ok        = write && (state == ST_IDLE);
  assign wr_clear     = wr_ok && (address[15:8] == REG_CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (start) state <= ST_FILT_X;
        ST_FILT_X: state <= ST_FILT_Y;
        ST_FILT_Y: state <= ST_FILT_Z;
        ST_FILT_Z: state <= ST_COMMIT;
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: capture; shift is frozen here so a later shift write waits for the next sample.
  always_ff @(posedge clk) begin
    if (start) begin
      sensor_p0 <= sample_sensor[SIDX_W-1:0];
      x_p0      <= $signed(sample_x);
      y_p0      <= $signed(sample_y);
      z_p0      <= $signed(sample_z);
      temp_p0   <= sample_temp;
      shift_p0  <= shift_q;
    end
  end

  always_comb begin
    axis        = 2'd0;
    axis_sample = x_p0;
    case (state)
      ST_FILT_Y: begin axis = 2'd1; axis_sample = y_p0; end
      ST_FILT_Z: begin axis = 2'd2; axis_sample = z_p0; end
      default: ;
    endcase
  end

  ball_joint_ema u_ema (
    .acc      (acc[sensor_p0][axis]),
    .sample   (axis_sample),
    .shift    (shift_p0),
    .primed   (primed[sensor_p0]),
    .acc_next (acc_next)
  );

  // Filter stages write back one axis per cycle; COMMIT publishes the sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        for (int a = 0; a < 3; a++) acc[i][a] <= '0;
        temp[i]  <= '0;
        count[i] <= '0;
      end
      primed    <= '0;
      err_count <= '0;
    end else if (wr_clear) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        for (int a = 0; a < 3; a++) acc[i][a] <= '0;
        count[i] <= '0;
      end
      primed    <= '0;
      err_count <= '0;
    end else begin
      if (capture && !sensor_ok) err_count <= sat_inc16(err_count);
      if (filt_active) acc[sensor_p0][axis] <= acc_next;
      if (state == ST_COMMIT) begin
        temp[sensor_p0]   <= temp_p0;
        count[sensor_p0]  <= sat_inc32(count[sensor_p0]);
        primed[sensor_p0] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        if (state == ST_COMMIT && int'(sensor_p0) == i) timer[i] <= '0;
        else if (timer[i] < timeout_q)                  timer[i] <= timer[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stale = '0;
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) stale[i] = (timer[i] >= timeout_q) || !primed[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= 3'(DEFAULT_SHIFT);
      timeout_q <= 32'(DEFAULT_TIMEOUT);
    end else if (wr_ok) begin
      if (address[15:8] == REG_SHIFT)   shift_q   <= writedata[2:0];
      if (address[15:8] == REG_TIMEOUT) timeout_q <= writedata;
    end
  end

  assign rd_sensor  = address[SIDX_W-1:0];
  assign rd_sens_ok = address[7:0] < N_SENS;

  always_comb begin
    rd_value = DEADBEEF;
    case (address[15:8])
      REG_X:       if (rd_sens_ok) rd_value = filt_out(acc[rd_sensor][0]);
      REG_Y:       if (rd_sens_ok) rd_value = filt_out(acc[rd_sensor][1]);
      REG_Z:       if (rd_sens_ok) rd_value = filt_out(acc[rd_sensor][2]);
      REG_TEMP:    if (rd_sens_ok) rd_value = {20'd0, temp[rd_sensor]};
      REG_COUNT:   if (rd_sens_ok) rd_value = count[rd_sensor];
      REG_STATUS:  if (rd_sens_ok) rd_value = {30'd0, primed[rd_sensor], stale[rd_sensor]};
      REG_ERR:     rd_value = {16'd0, err_count};
      REG_SHIFT:   rd_value = {29'd0, shift_q};
      REG_TIMEOUT: rd_value = timeout_q;
      default: ;
    endcase
  end

  // Reads latch only while idle so a sensor is never seen mid-update; the wait
  // state re-arms whenever the filter is busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata  <= '0;
      wait_flag <= 1'b1;
    end else if (read) begin
      if (state != ST_IDLE) begin
        wait_flag <= 1'b1;
      end else if (wait_flag) begin
        readdata  <= rd_value;
        wait_flag <= 1'b0;
      end else begin
        wait_flag <= 1'b1;
      end
    end else begin
      wait_flag <= 1'b1;
    end
  end

endmodule
